// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter sharing the common data bus among N_REQ
//               functional-unit result streams. The winner's payload is
//               registered into a one-entry output slot and offered to the
//               CDB consumers under a valid/ready handshake. A mispredict
//               flushes the slot and blocks all grants in the same cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_REQ      number of requesters (>= 2, any value)
//   T          payload type
//   IDX_W      source index width, derived from N_REQ
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   mispredict flush request, sampled synchronously
//   req_valid  per-requester valid
//   req_data   per-requester payload
//   req_ready  per-requester grant (one-hot or zero)
//   cdb_ready  CDB consumer accepts this cycle
//   cdb_valid  output slot holds a valid result
//   cdb_data   slot payload (zero while cdb_valid is low)
//   cdb_src    producing requester index (zero while cdb_valid is low)
// ============================================================================
module cdb_arbiter #(
    parameter int  N_REQ = 4,
    parameter type T     = logic [31:0],
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mispredict,
    input  logic [N_REQ-1:0] req_valid,
    input  T                 req_data [N_REQ],
    output logic [N_REQ-1:0] req_ready,
    input  logic             cdb_ready,
    output logic             cdb_valid,
    output T                 cdb_data,
    output logic [IDX_W-1:0] cdb_src
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic             slot_full;
    T                 slot_data;
    logic [IDX_W-1:0] slot_src;
    logic [IDX_W-1:0] rr_ptr;

    logic             can_load;
    logic             found;
    logic [IDX_W-1:0] winner;

    // Reset is folded in so that no grant is advertised while held in reset,
    // even though the slot already reads as empty.
    assign can_load = reset && !mispredict && (!slot_full || cdb_ready);

    // Rotating priority scan starting at rr_ptr. The index wrap is an explicit
    // subtract so non-power-of-two N_REQ never visits a nonexistent requester.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && can_load) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full <= 1'b0;
            slot_data <= '0;
            slot_src  <= '0;
            rr_ptr    <= '0;
        end else if (mispredict) begin
            // Flush the slot; priority pointer is preserved.
            slot_full <= 1'b0;
            slot_data <= '0;
            slot_src  <= '0;
        end else if (can_load && found) begin
            slot_full <= 1'b1;
            slot_data <= req_data[winner];
            slot_src  <= winner;
            rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
        end else if (cdb_ready) begin
            // Drain with nothing to reload.
            slot_full <= 1'b0;
        end
    end

    assign cdb_valid = slot_full && !mispredict;
    assign cdb_data  = cdb_valid ? slot_data : '0;
    assign cdb_src   = cdb_valid ? slot_src  : '0;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter (N_REQ=4 and N_REQ=3).
//               Expected CDB results are queued when a grant is issued; a
//               monitor per instance pops and compares on every CDB transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- N_REQ = 4 instance ----------------
    logic        reset4, misp4, cdb_ready4, cdb_valid4;
    logic [3:0]  req_valid4, req_ready4;
    logic [31:0] data4 [4];
    logic [31:0] cdb_data4;
    logic [1:0]  cdb_src4;

    cdb_arbiter #(.N_REQ(4), .T(logic [31:0])) dut4 (
        .clk(clk), .reset(reset4), .mispredict(misp4),
        .req_valid(req_valid4), .req_data(data4), .req_ready(req_ready4),
        .cdb_ready(cdb_ready4), .cdb_valid(cdb_valid4),
        .cdb_data(cdb_data4), .cdb_src(cdb_src4)
    );

    // ---------------- N_REQ = 3 instance ----------------
    logic        reset3, cdb_ready3, cdb_valid3;
    logic [2:0]  req_valid3, req_ready3;
    logic [31:0] data3 [3];
    logic [31:0] cdb_data3;
    logic [1:0]  cdb_src3;

    cdb_arbiter #(.N_REQ(3), .T(logic [31:0])) dut3 (
        .clk(clk), .reset(reset3), .mispredict(1'b0),
        .req_valid(req_valid3), .req_data(data3), .req_ready(req_ready3),
        .cdb_ready(cdb_ready3), .cdb_valid(cdb_valid3),
        .cdb_data(cdb_data3), .cdb_src(cdb_src3)
    );

    logic [33:0] q4 [$];
    logic [33:0] q3 [$];

    // Monitors: inputs only change just after posedge, so a negedge sample
    // with valid && ready is exactly a transfer at the next edge.
    always @(negedge clk) begin
        if (cdb_valid4 && cdb_ready4) begin
            if (q4.size() == 0) chk("cdb4_unexpected", {cdb_src4, cdb_data4}, 64'h0);
            else chk("cdb4", {cdb_src4, cdb_data4}, q4.pop_front());
        end
        if (cdb_valid3 && cdb_ready3) begin
            if (q3.size() == 0) chk("cdb3_unexpected", {cdb_src3, cdb_data3}, 64'h0);
            else chk("cdb3", {cdb_src3, cdb_data3}, q3.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rot4 [6];
    logic [2:0] rot3 [7];
    logic [1:0] src3 [7];

    initial begin
        rot4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rot3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        src3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) data4[i] = 32'hA0 + i;
        for (int i = 0; i < 3; i++) data3[i] = 32'hB0 + i;
        reset4 = 1'b0; misp4 = 1'b0; cdb_ready4 = 1'b1; req_valid4 = 4'b1111;
        reset3 = 1'b0; cdb_ready3 = 1'b1; req_valid3 = 3'b111;

        // Reset held: everything quiet.
        step(); step();
        @(negedge clk);
        chk("rst_valid", cdb_valid4, 0);
        chk("rst_data", cdb_data4, 0);
        chk("rst_src", cdb_src4, 0);
        chk("rst_ready", req_ready4, 0);

        // Release and rotate: 0,1,2,3,0,1.
        step();
        reset4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rot_ready%0d", k), req_ready4, rot4[k]);
            q4.push_back({2'(k % 4), 32'hA0 + 32'(k % 4)});
            step();
        end

        // Backpressure: slot holds A1 from requester 1.
        cdb_ready4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", req_ready4, 0);
            chk("bp_valid", cdb_valid4, 1);
            chk("bp_data", cdb_data4, 32'hA1);
            chk("bp_src", cdb_src4, 1);
            step();
        end
        cdb_ready4 = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready4, 4'b0100);
        q4.push_back({2'd2, 32'hA2});
        step();

        // Sparse requests and wrap (rr_ptr now 3).
        req_valid4 = 4'b1000;
        @(negedge clk);
        chk("sp_ready3", req_ready4, 4'b1000);
        q4.push_back({2'd3, 32'hA3});
        step();
        req_valid4 = 4'b0100;                 // rr_ptr 0, only requester 2
        @(negedge clk);
        chk("sp_ready2", req_ready4, 4'b0100);
        q4.push_back({2'd2, 32'hA2});
        step();
        req_valid4 = 4'b1001;                 // rr_ptr 3
        @(negedge clk);
        chk("sp_wrap3", req_ready4, 4'b1000);
        q4.push_back({2'd3, 32'hA3});
        step();
        @(negedge clk);                       // rr_ptr 0
        chk("sp_wrap0", req_ready4, 4'b0001);
        q4.push_back({2'd0, 32'hA0});
        step();

        // Mispredict with slot full (src 0) and rr_ptr 1.
        req_valid4 = 4'b1111;
        misp4 = 1'b1;
        @(negedge clk);
        chk("mp_valid", cdb_valid4, 0);
        chk("mp_ready", req_ready4, 0);
        void'(q4.pop_back());                 // flushed entry never reaches the CDB
        step();
        misp4 = 1'b0;
        @(negedge clk);
        chk("mp_after_valid", cdb_valid4, 0);
        chk("mp_after_ready", req_ready4, 4'b0010);
        q4.push_back({2'd1, 32'hA1});
        step();

        // Asynchronous reset mid-stream with slot full and stalled.
        cdb_ready4 = 1'b0;
        @(negedge clk);
        chk("ar_pre_valid", cdb_valid4, 1);
        #2;
        reset4 = 1'b0;
        #1;
        chk("ar_valid", cdb_valid4, 0);
        chk("ar_data", cdb_data4, 0);
        chk("ar_src", cdb_src4, 0);
        chk("ar_ready", req_ready4, 0);
        void'(q4.pop_back());                 // in-flight result lost to reset
        step();
        reset4 = 1'b1;
        cdb_ready4 = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", req_ready4, 4'b0001);
        q4.push_back({2'd0, 32'hA0});
        step();
        req_valid4 = 4'b0000;
        step(); step();
        @(negedge clk);
        chk("q4_empty", q4.size(), 0);
        chk("idle_valid", cdb_valid4, 0);

        // Non-power-of-two instance: 7 grants 0,1,2,0,1,2,0.
        step();
        reset3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("n3_ready%0d", k), req_ready3, rot3[k]);
            q3.push_back({src3[k], 32'hB0 + 32'(src3[k])});
            step();
        end
        req_valid3 = 3'b000;
        step(); step();
        @(negedge clk);
        chk("q3_empty", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
